// File: rtl/dfp_normalize128_pkg.sv
// Shared types and constants for the 128-bit decimal floating-point
// normalizer.
//   DFP128UN     : unpacked DFP128 result (N+1 BCD digits, digit 0 = round digit)
//   DFP128NI     : latched normalizer input record
//   norm_state_t : normalizer FSM states
//   fold_round() : folds sticky information into the round digit
package dfp_normalize128_pkg;

  localparam int DFP_N  = 34;   // significand digits of the packed format
  localparam int DFP_ID = 70;   // wide significand digits from the producers

  localparam logic [13:0] DFP128_EXP_MAX = 14'h3FFE;
  localparam logic [13:0] DFP128_EXP_INF = 14'h3FFF;

  typedef struct packed {
    logic                     sign;
    logic                     nan;
    logic                     qnan;
    logic                     snan;
    logic                     infinity;
    logic [13:0]              exp;
    logic [(DFP_N+1)*4-1:0]   sig;
  } DFP128UN;

  typedef struct packed {
    logic                     sign;
    logic [15:0]              exp;
    logic [DFP_ID*4-1:0]      sig;
    logic                     nan;
    logic                     qnan;
    logic                     snan;
    logic                     inf;
  } DFP128NI;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_PACK,
    ST_DONE
  } norm_state_t;

  // A 0 or 5 round digit is ambiguous to the rounder (exact zero / exact
  // half); bump it by one when anything non-zero was discarded below it.
  function automatic logic [3:0] fold_round(input logic [3:0] d, input logic sticky);
    logic [3:0] r;
    r = d;
    if (sticky && d == 4'd0) r = 4'd1;
    if (sticky && d == 4'd5) r = 4'd6;
    return r;
  endfunction

endpackage

// File: rtl/dfp_normalize128_lzc.sv
// BCD leading-zero-digit counter.
//   W   : number of BCD digits examined (MSD at the top of sig)
//   sig : in,  W*4 bits
//   lz  : out, count of leading zero digits, W when every digit is zero
module dfp_normalize128_lzc #(
  parameter int W = 4
) (
  input  logic [W*4-1:0]          sig,
  output logic [$clog2(W+1)-1:0]  lz
);

  localparam int LW = $clog2(W+1);

  logic [W-1:0] nz;

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_nz
      assign nz[gi] = |sig[gi*4 +: 4];
    end
  endgenerate

  // Scan upward from the LSD so the most significant non-zero digit wins.
  always_comb begin
    lz = LW'(W);
    for (int i = 0; i < W; i++) begin
      if (nz[i]) lz = LW'(W - 1 - i);
    end
  end

endmodule

// File: rtl/dfp_normalize128.sv
// Iterative BCD normalizer and sticky-folder for DFP128, placed directly in
// front of the rounder. Shifts a wide BCD significand left until its MSD is
// non-zero or the exponent reaches zero, then emits N+1 digits with all
// discarded digits folded into the round digit.
//
// Build option: DFPNORM_FAST_EN -- replace the SD-digit-per-cycle shifter with
// a single-cycle full-width leading-zero count and barrel shift.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   ce                 clock enable, freezes all state when low
//   i_valid / i_ready  input handshake (ready only in IDLE)
//   i_sign, i_exp      sign, 16-bit biased exponent of the top N+1 digits
//   i_sig              ID BCD digits, MSD at top
//   i_nan/qnan/snan/inf special-value flags
//   o_valid / o_ready  output handshake
//   o                  DFP128UN result (digit 0 of o.sig is the round digit)
module dfp_normalize128
  import dfp_normalize128_pkg::*;
#(
  parameter int N  = DFP_N,
  parameter int ID = DFP_ID,
  parameter int SD = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ce,
  input  logic            i_valid,
  output logic            i_ready,
  input  logic            i_sign,
  input  logic [15:0]     i_exp,
  input  logic [ID*4-1:0] i_sig,
  input  logic            i_nan,
  input  logic            i_qnan,
  input  logic            i_snan,
  input  logic            i_inf,
  output logic            o_valid,
  input  logic            o_ready,
  output DFP128UN         o
);

  localparam int SW = ID * 4;
  localparam int OW = (N + 1) * 4;

`ifdef DFPNORM_FAST_EN
  localparam int LZW = ID;
`else
  localparam int LZW = SD;
`endif
  localparam int LW = $clog2(LZW + 1);

  norm_state_t state_reg, state_next;
  DFP128NI     in_reg, in_next;
  DFP128UN     o_reg, o_next;
  DFP128UN     pack_res;

  logic [LW-1:0] lz;
  logic [LW-1:0] shift_amt;

  dfp_normalize128_lzc #(.W(LZW)) u_lzc (
    .sig (in_reg.sig[SW-1 -: LZW*4]),
    .lz  (lz)
  );

  // The exponent may not go below zero: a smaller exponent truncates the
  // shift and the result becomes a denormal.
  always_comb begin
    shift_amt = lz;
    if ({{(16-LW){1'b0}}, lz} > in_reg.exp) shift_amt = in_reg.exp[LW-1:0];
  end

  // Result formatting for the PACK cycle.
  always_comb begin
    logic [OW-1:0] top;
    logic          sticky;
    top      = in_reg.sig[SW-1 -: OW];
    sticky   = |in_reg.sig[SW-OW-1:0];
    pack_res = '0;
    pack_res.sign = in_reg.sign;
    if (in_reg.nan || in_reg.qnan || in_reg.snan || in_reg.inf) begin
      pack_res.nan      = in_reg.nan;
      pack_res.qnan     = in_reg.qnan;
      pack_res.snan     = in_reg.snan;
      pack_res.infinity = in_reg.inf;
      pack_res.sig      = top;
      pack_res.exp      = in_reg.exp[13:0];
    end else if (~|in_reg.sig) begin
      pack_res.exp = in_reg.exp[13:0];
    end else if (in_reg.exp > {2'b00, DFP128_EXP_MAX}) begin
      pack_res.infinity = 1'b1;
      pack_res.exp      = DFP128_EXP_INF;
    end else begin
      pack_res.sig = {top[OW-1:4], fold_round(top[3:0], sticky)};
      pack_res.exp = in_reg.exp[13:0];
    end
  end

  always_comb begin
    state_next = state_reg;
    in_next    = in_reg;
    o_next     = o_reg;
    case (state_reg)
      ST_IDLE: begin
        if (i_valid) begin
          in_next.sign = i_sign;
          in_next.exp  = i_exp;
          in_next.sig  = i_sig;
          in_next.nan  = i_nan;
          in_next.qnan = i_qnan;
          in_next.snan = i_snan;
          in_next.inf  = i_inf;
          if (i_nan || i_qnan || i_snan || i_inf || ~|i_sig) state_next = ST_PACK;
          else                                               state_next = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        in_next.sig = in_reg.sig << {shift_amt, 2'b00};
        in_next.exp = in_reg.exp - 16'(shift_amt);
`ifdef DFPNORM_FAST_EN
        state_next = ST_PACK;
`else
        // A full SD-digit shift means more leading zeros may follow.
        if (shift_amt < LW'(SD)) state_next = ST_PACK;
`endif
      end
      ST_PACK: begin
        o_next     = pack_res;
        state_next = ST_DONE;
      end
      ST_DONE: begin
        if (o_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      in_reg    <= '0;
      o_reg     <= '0;
    end else if (ce) begin
      state_reg <= state_next;
      in_reg    <= in_next;
      o_reg     <= o_next;
    end
  end

  assign i_ready = (state_reg == ST_IDLE);
  assign o_valid = (state_reg == ST_DONE);
  assign o       = o_reg;

endmodule

// File: tb/tb_dfp_normalize128.sv
module tb_dfp_normalize128;
  import dfp_normalize128_pkg::*;

  localparam int N  = 34;
  localparam int ID = 70;
  localparam int SD = 4;
  localparam int SW = ID * 4;
  localparam int OW = (N + 1) * 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic          i_sign = 1'b0;
  logic [15:0]   i_exp = '0;
  logic [SW-1:0] i_sig = '0;
  logic          i_nan = 1'b0, i_qnan = 1'b0, i_snan = 1'b0, i_inf = 1'b0;
  logic          o_valid;
  logic          o_ready = 1'b1;
  DFP128UN       o;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    DFP128UN res;
    int      lat;
  } exp_t;
  exp_t sb_q[$];

  dfp_normalize128 #(.N(N), .ID(ID), .SD(SD)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce),
    .i_valid(i_valid), .i_ready(i_ready),
    .i_sign(i_sign), .i_exp(i_exp), .i_sig(i_sig),
    .i_nan(i_nan), .i_qnan(i_qnan), .i_snan(i_snan), .i_inf(i_inf),
    .o_valid(o_valid), .o_ready(o_ready), .o(o)
  );

  always #5 clk = ~clk;

  function automatic DFP128NI mk(input logic sign, input logic [15:0] e, input logic [SW-1:0] s,
                                 input logic nan, input logic qnan, input logic snan, input logic inf);
    DFP128NI r;
    r.sign = sign; r.exp = e; r.sig = s;
    r.nan = nan; r.qnan = qnan; r.snan = snan; r.inf = inf;
    return r;
  endfunction

  function automatic int lead_zeros(input logic [SW-1:0] s);
    int lz = 0;
    for (int i = ID - 1; i >= 0; i--) begin
      if (s[i*4 +: 4] != 4'd0) break;
      lz++;
    end
    return lz;
  endfunction

  // Reference result: one full shift by min(total leading zeros, exp).
  function automatic DFP128UN model(input DFP128NI in);
    DFP128UN       r;
    logic [SW-1:0] sh;
    logic [15:0]   e;
    logic [3:0]    rd;
    logic          st;
    int            lz, s;
    r = '0;
    r.sign = in.sign;
    lz = lead_zeros(in.sig);
    if (in.nan || in.qnan || in.snan || in.inf) begin
      r.nan = in.nan; r.qnan = in.qnan; r.snan = in.snan; r.infinity = in.inf;
      r.sig = in.sig[SW-1 -: OW];
      r.exp = in.exp[13:0];
      return r;
    end
    if (lz == ID) begin
      r.exp = in.exp[13:0];
      return r;
    end
    s  = (lz < int'(in.exp)) ? lz : int'(in.exp);
    sh = in.sig << (4 * s);
    e  = in.exp - 16'(s);
    if (e > 16'h3FFE) begin
      r.infinity = 1'b1;
      r.exp = 14'h3FFF;
      return r;
    end
    r.sig = sh[SW-1 -: OW];
    st = |sh[SW-OW-1:0];
    rd = r.sig[3:0];
    if (st && rd == 4'd0) rd = 4'd1;
    else if (st && rd == 4'd5) rd = 4'd6;
    r.sig[3:0] = rd;
    r.exp = e[13:0];
    return r;
  endfunction

  // Cycles from the accepting edge to the edge at which o_valid is first seen.
  function automatic int model_lat(input DFP128NI in);
    int lz, le;
    lz = lead_zeros(in.sig);
    if (in.nan || in.qnan || in.snan || in.inf || lz == ID) return 2;
`ifdef DFPNORM_FAST_EN
    return 3;
`else
    le = (lz < int'(in.exp)) ? lz : int'(in.exp);
    return le / SD + 3;
`endif
  endfunction

  task automatic push_exp(input DFP128NI in);
    exp_t e;
    e.res = model(in);
    e.lat = model_lat(in);
    sb_q.push_back(e);
  endtask

  // Drives one operand and waits for the result; handshakes it only when
  // o_ready is already high. Returns at the sampling negedge when o_ready is low.
  task automatic run_op(input DFP128NI in, output DFP128UN got, output int lat, output bit to);
    int c;
    to = 1'b0; lat = 0; got = '0;
    i_sign = in.sign; i_exp = in.exp; i_sig = in.sig;
    i_nan = in.nan; i_qnan = in.qnan; i_snan = in.snan; i_inf = in.inf;
    i_valid = 1'b1;
    c = 0;
    forever begin
      @(negedge clk);
      if (i_ready && ce) break;
      c++;
      if (c > 50) begin to = 1'b1; i_valid = 1'b0; return; end
    end
    @(posedge clk); #1;
    i_valid = 1'b0;
    c = 0;
    forever begin
      @(negedge clk);
      if (o_valid) break;
      c++;
      if (c > 200) begin to = 1'b1; return; end
      @(posedge clk);
    end
    lat = c + 1;
    got = o;
    if (o_ready) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (i_ready !== 1'b1 || o_valid !== 1'b0 || o !== '0)
      $display("FAIL reset: i_ready=%b o_valid=%b o=%h, required 1 0 0", i_ready, o_valid, o);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // Scoreboarded transaction with result and latency comparisons.
  task automatic test_op(input string name, input DFP128NI in);
    DFP128UN got; int lat; bit to; exp_t e;
    push_exp(in);
    run_op(in, got, lat, to);
    e = sb_q.pop_front();
    $display("txn %s: lat=%0d exp=%h inf=%b sig=%h", name, lat, got.exp, got.infinity, got.sig);
    n_checks++;
    if (to) $display("FAIL %s timeout: no o_valid within bound", name);
    else if (got !== e.res) $display("FAIL %s result: got %h, required %h", name, got, e.res);
    else n_pass++;
    n_checks++;
    if (lat !== e.lat) $display("FAIL %s latency: got %0d, required %0d", name, lat, e.lat);
    else n_pass++;
  endtask

  task automatic test_shift();
    logic [SW-1:0] s;
    DFP128UN got; int lat; bit to; exp_t e;
    s = '0; s[3:0] = 4'd1;
    // Single 1 in the LSD, plenty of exponent: 69-digit shift.
    push_exp(mk(1'b0, 16'd100, s, 0, 0, 0, 0));
    run_op(mk(1'b0, 16'd100, s, 0, 0, 0, 0), got, lat, to);
    e = sb_q.pop_front();
    $display("txn shift_full: lat=%0d exp=%h sig=%h", lat, got.exp, got.sig);
    n_checks++;
    if (to || got.exp !== 14'd31 || got.sig !== {4'd1, {(OW-4){1'b0}}})
      $display("FAIL shift_full: exp=%h sig=%h, required exp=001f sig=1 then zeros", got.exp, got.sig);
    else n_pass++;
    n_checks++;
    if (got !== e.res) $display("FAIL shift_full result: got %h, required %h", got, e.res);
    else n_pass++;
    n_checks++;
`ifdef DFPNORM_FAST_EN
    if (lat !== 3) $display("FAIL shift_full latency: got %0d, required 3", lat);
`else
    if (lat !== 20) $display("FAIL shift_full latency: got %0d, required 20", lat);
`endif
    else n_pass++;
    // Exponent runs out after 10 digits: denormal, the 1 is discarded as sticky.
    test_op("shift_denorm", mk(1'b1, 16'd10, s, 0, 0, 0, 0));
    test_op("shift_exp0", mk(1'b0, 16'd0, s, 0, 0, 0, 0));
    s = '0; s[(ID-6)*4 +: 4] = 4'd7; s[7:4] = 4'd2;
    test_op("shift_lz5", mk(1'b0, 16'd40, s, 0, 0, 0, 0));
    s = '0; s[(ID-4)*4 +: 4] = 4'd9;
    test_op("shift_lz3_exp3", mk(1'b0, 16'd3, s, 0, 0, 0, 0));
  endtask

  task automatic test_fold();
    logic [SW-1:0] s;
    s = '0; s[SW-4 +: 4] = 4'd1; s[(ID-N-1)*4 +: 4] = 4'd5; s[3:0] = 4'd3;
    test_op("fold_5_sticky", mk(1'b0, 16'd500, s, 0, 0, 0, 0));
    s[3:0] = 4'd0;
    test_op("fold_5_exact", mk(1'b0, 16'd500, s, 0, 0, 0, 0));
    s[(ID-N-1)*4 +: 4] = 4'd0; s[8 +: 4] = 4'd4;
    test_op("fold_0_sticky", mk(1'b1, 16'd77, s, 0, 0, 0, 0));
    s[(ID-N-1)*4 +: 4] = 4'd7;
    test_op("fold_7_sticky", mk(1'b0, 16'd77, s, 0, 0, 0, 0));
  endtask

  task automatic test_overflow();
    logic [SW-1:0] s;
    s = '0; s[SW-4 +: 4] = 4'd8; s[(ID-N-1)*4 +: 4] = 4'd2;
    test_op("ovf_4000", mk(1'b0, 16'h4000, s, 0, 0, 0, 0));
    test_op("ovf_3fff", mk(1'b1, 16'h3FFF, s, 0, 0, 0, 0));
    test_op("ovf_3ffe", mk(1'b0, 16'h3FFE, s, 0, 0, 0, 0));
  endtask

  task automatic test_special_hold();
    logic [SW-1:0] s;
    DFP128UN got; int lat; bit to; exp_t e; int bad;
    for (int i = 0; i < ID; i++) s[i*4 +: 4] = 4'($urandom_range(0, 9));
    s[SW-4 +: 4] = 4'd0; s[11:8] = 4'd5;
    push_exp(mk(1'b1, 16'h0123, s, 1, 0, 1, 0));
    o_ready = 1'b0;
    run_op(mk(1'b1, 16'h0123, s, 1, 0, 1, 0), got, lat, to);
    e = sb_q.pop_front();
    $display("txn snan_hold: lat=%0d snan=%b sig=%h", lat, got.snan, got.sig);
    n_checks++;
    if (to || got !== e.res) $display("FAIL snan_hold result: got %h, required %h", got, e.res);
    else n_pass++;
    n_checks++;
    if (lat !== 2) $display("FAIL snan_hold latency: got %0d, required 2", lat);
    else n_pass++;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); @(negedge clk);
      if (o_valid !== 1'b1 || o !== e.res) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL snan_hold stability: %0d unstable cycles, required 0", bad);
    else n_pass++;
    o_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b0 || i_ready !== 1'b1)
      $display("FAIL snan_release: o_valid=%b i_ready=%b, required 0 1", o_valid, i_ready);
    else n_pass++;
    test_op("qnan", mk(1'b0, 16'd9, s, 1, 1, 0, 0));
    test_op("inf", mk(1'b1, 16'd0, '0, 0, 0, 0, 1));
    test_op("zero", mk(1'b1, 16'd1234, '0, 0, 0, 0, 0));
  endtask

  task automatic test_ce();
    logic [SW-1:0] s;
    DFP128UN got; int lat; bit to; exp_t e; int bad;
    s = '0; s[(ID-2)*4 +: 4] = 4'd3; s[0 +: 4] = 4'd1;
    push_exp(mk(1'b0, 16'd200, s, 0, 0, 0, 0));
    o_ready = 1'b0;
    run_op(mk(1'b0, 16'd200, s, 0, 0, 0, 0), got, lat, to);
    e = sb_q.pop_front();
    $display("txn ce_freeze: lat=%0d exp=%h sig=%h", lat, got.exp, got.sig);
    n_checks++;
    if (to || got !== e.res) $display("FAIL ce_freeze result: got %h, required %h", got, e.res);
    else n_pass++;
    ce = 1'b0; o_ready = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      if (o_valid !== 1'b1 || o !== e.res) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL ce_freeze hold: %0d cycles left DONE, required 0", bad);
    else n_pass++;
    ce = 1'b1;
    @(posedge clk); @(negedge clk);
    n_checks++;
    if (o_valid !== 1'b0) $display("FAIL ce_release: o_valid=%b, required 0", o_valid);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [SW-1:0] s;
    logic [15:0]   e16;
    int            lz;
    DFP128UN got; int lat; bit to; exp_t e;
    for (int t = 0; t < 16; t++) begin
      lz = $urandom_range(0, ID - 1);
      s = '0;
      for (int i = 0; i < ID - lz; i++) s[i*4 +: 4] = 4'($urandom_range(0, 9));
      s[(ID-1-lz)*4 +: 4] = 4'($urandom_range(1, 9));
      e16 = (t % 4 == 3) ? 16'(16'h3FE0 + $urandom_range(0, 100)) : 16'($urandom_range(0, 90));
      push_exp(mk(1'($urandom_range(0, 1)), e16, s, 0, 0, 0, 0));
      run_op(mk(sb_q[$].res.sign, e16, s, 0, 0, 0, 0), got, lat, to);
      e = sb_q.pop_front();
      $display("txn rand%0d: lz=%0d exp_in=%h lat=%0d exp=%h inf=%b", t, lz, e16, lat, got.exp, got.infinity);
      n_checks++;
      if (to || got !== e.res || lat !== e.lat)
        $display("FAIL rand%0d: got %h lat %0d, required %h lat %0d", t, got, lat, e.res, e.lat);
      else n_pass++;
      // IDLE must be re-entered immediately after the handshake.
      n_checks++;
      if (i_ready !== 1'b1) $display("FAIL rand%0d reentry: i_ready=%b, required 1", t, i_ready);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    int highs;
    i_sig = '0; i_sig[3:0] = 4'd1; i_exp = 16'd100; i_sign = 1'b0;
    i_nan = 0; i_qnan = 0; i_snan = 0; i_inf = 0;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if (i_ready !== 1'b1 || o_valid !== 1'b0)
      $display("FAIL abort: i_ready=%b o_valid=%b, required 1 0", i_ready, o_valid);
    else n_pass++;
    @(posedge clk); #1;
    rst_n = 1'b1;
    highs = 0;
    repeat (25) begin
      @(negedge clk);
      if (o_valid) highs++;
    end
    $display("txn abort: o_valid high cycles after abort=%0d", highs);
    n_checks++;
    if (highs != 0) $display("FAIL abort_no_output: o_valid high %0d cycles, required 0", highs);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_shift();
    test_fold();
    test_overflow();
    test_special_hold();
    test_ce();
    test_back_to_back();
    test_abort();
    n_checks++;
    if (sb_q.size() != 0) $display("FAIL scoreboard: %0d entries left, required 0", sb_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
